reg_scoreboard: RTL

- Tracks in-flight writes to the 8x16 register file and blocks decode until each source register holds its final value.
- Sits at decode/issue. It watches the same write-port signals the writeback stage drives into the register file (write select, write enable) as retirement events.
- Produces a stall that freezes issue, plus a sticky protocol-error flag.
- Register file has no write-before-read bypass, so a value written in cycle N is readable only from cycle N+1.

---
 rtl/reg_scoreboard.sv | 80 ++++++++
 1 files changed

// File: rtl/reg_scoreboard.sv
// Register scoreboard for decode/issue: counts in-flight writes per architectural
// register and stalls issue until every source register holds its final value.
module reg_scoreboard #(
  parameter  int NUM_REGS = 8,
  parameter  int CNT_W    = 2,
  localparam int SEL_W    = $clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                issueValid,
  input  logic                issueRead1En,
  input  logic [SEL_W-1:0]    issueRead1Sel,
  input  logic                issueRead2En,
  input  logic [SEL_W-1:0]    issueRead2Sel,
  input  logic                issueWriteEn,
  input  logic [SEL_W-1:0]    issueWriteSel,
  input  logic                writeEn,
  input  logic [SEL_W-1:0]    writeRegSel,
  output logic                stall,
  output logic                issueAccept,
  output logic [NUM_REGS-1:0] busy,
  output logic                err
);

  localparam logic [CNT_W-1:0] CNT_FULL = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [NUM_REGS-1:0][CNT_W-1:0] cnt_q;
  logic [NUM_REGS-1:0][CNT_W-1:0] cnt_d;
  logic                           err_q;
  logic                           err_d;

  logic                hazard1;
  logic                hazard2;
  logic                full;
  logic                issue_write;
  logic [NUM_REGS-1:0] inc_vec;
  logic [NUM_REGS-1:0] dec_vec;
  logic [NUM_REGS-1:0] under_vec;

  // Hazards look only at registered counts: a retire landing this cycle is
  // not visible to readers until the next cycle (no register file bypass).
  always_comb begin
    hazard1     = issueRead1En & (cnt_q[issueRead1Sel] != '0);
    hazard2     = issueRead2En & (cnt_q[issueRead2Sel] != '0);
    full        = issueWriteEn & (cnt_q[issueWriteSel] == CNT_FULL);
    stall       = issueValid & (hazard1 | hazard2 | full);
    issueAccept = issueValid & ~stall;
    issue_write = issueAccept & issueWriteEn;
  end

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
    assign inc_vec[gi]   = issue_write & (issueWriteSel == SEL_W'(gi));
    assign dec_vec[gi]   = writeEn & (writeRegSel == SEL_W'(gi));
    assign under_vec[gi] = dec_vec[gi] & (cnt_q[gi] == '0);

    // Issue and retire to the same register cancel; a retire on an empty
    // counter saturates at zero instead of wrapping.
    assign cnt_d[gi] =
        (inc_vec[gi] & ~dec_vec[gi])                       ? cnt_q[gi] + CNT_ONE :
        (dec_vec[gi] & ~inc_vec[gi] & (cnt_q[gi] != '0))   ? cnt_q[gi] - CNT_ONE :
                                                             cnt_q[gi];

    assign busy[gi] = (cnt_q[gi] != '0);
  end

  assign err_d = err_q | (|under_vec);
  assign err   = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

endmodule
